// File: rtl/vec_lsu_pkg.sv
// Shared definitions for the vector load/store unit.
// Holds the vector geometry (VLEN lanes of ELEM_W bits, ELEM_BYTES per element),
// the controller state enum and a helper that forms per-element byte addresses.
package vec_lsu_pkg;

  localparam int VLEN       = 4;
  localparam int ELEM_W     = 32;
  localparam int ELEM_BYTES = 4;
  localparam int IDX_W      = $clog2(VLEN);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VLEN - 1);

  typedef logic [ELEM_W-1:0] elem_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WB,
    ST_DONE
  } lsu_state_e;

  // Byte address of element idx; 32-bit arithmetic wraps naturally past 2^32.
  function automatic logic [31:0] elem_addr(input logic [31:0] base,
                                            input logic [IDX_W-1:0] idx);
    return base + (32'(idx) * 32'(ELEM_BYTES));
  endfunction

endpackage

// File: rtl/vector_lsu.sv
// Vector load/store unit: moves one VLEN-element vector between a vector
// register bank and a single-port request/grant memory, one element at a time.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start, is_store           launch request (sampled in IDLE) and direction
//   base_addr, vreg           byte address of element 0, vector register number
//   vs_sel / vin1..vin4       bank read select and the four returned lanes
//   mem_req/we/addr/wdata     memory request channel (held until mem_gnt)
//   mem_gnt, mem_rvalid/rdata grant and read-data return
//   vw_en, vw_vd, vw1..vw4    bank full-vector write port (loads only)
//   busy, done                not idle; one-cycle completion pulse
module vector_lsu
  import vec_lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [31:0]       base_addr,
  input  logic [1:0]        vreg,
  output logic [1:0]        vs_sel,
  input  logic [ELEM_W-1:0] vin1,
  input  logic [ELEM_W-1:0] vin2,
  input  logic [ELEM_W-1:0] vin3,
  input  logic [ELEM_W-1:0] vin4,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              vw_en,
  output logic [1:0]        vw_vd,
  output logic [ELEM_W-1:0] vw1,
  output logic [ELEM_W-1:0] vw2,
  output logic [ELEM_W-1:0] vw3,
  output logic [ELEM_W-1:0] vw4,
  output logic              busy,
  output logic              done
);

  lsu_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             store_q;
  logic [1:0]       vreg_q;
  logic [31:0]      base_q;
  elem_t            lane_q [VLEN];
  // Bank write image: only refreshed when the last load element arrives, so
  // the bank port never exposes a partially filled vector and holds after WB.
  elem_t            vw_q   [VLEN];
  logic [1:0]       vd_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d is defaulted before the case so no path leaves it unassigned;
  // otherwise always_comb would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_REQ;
      ST_REQ: begin
        if (mem_gnt) begin
          if (!store_q)              state_d = ST_WAIT;
          else if (idx_q == IDX_LAST) state_d = ST_DONE;
        end
      end
      ST_WAIT: begin
        // rvalid is only meaningful here; elsewhere it is ignored entirely.
        if (mem_rvalid) state_d = (idx_q == IDX_LAST) ? ST_WB : ST_REQ;
      end
      ST_WB:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from registered state, so they are stable for a cycle)
  // ---------------------------------------------------------------------------
  always_comb begin
    vs_sel    = (state_q == ST_IDLE) ? vreg : vreg_q;
    mem_req   = (state_q == ST_REQ);
    mem_we    = mem_req && store_q;
    mem_addr  = mem_req ? elem_addr(base_q, idx_q) : '0;
    mem_wdata = (mem_req && store_q) ? lane_q[idx_q] : '0;
    vw_en     = (state_q == ST_WB);
    vw_vd     = vd_q;
    vw1       = vw_q[0];
    vw2       = vw_q[1];
    vw3       = vw_q[2];
    vw4       = vw_q[3];
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses <= so all updates see the pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      store_q <= 1'b0;
      vreg_q  <= '0;
      base_q  <= '0;
      vd_q    <= '0;
      // NOTE: the lane buffer and bank image are reset on purpose: an aborted
      // load must leave nothing behind that a later read could observe.
      for (int i = 0; i < VLEN; i++) begin
        lane_q[i] <= '0;
        vw_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            store_q   <= is_store;
            vreg_q    <= vreg;
            // Elements are word aligned; the low address bits are dropped.
            base_q    <= base_addr & ~32'(ELEM_BYTES - 1);
            idx_q     <= '0;
            lane_q[0] <= vin1;
            lane_q[1] <= vin2;
            lane_q[2] <= vin3;
            lane_q[3] <= vin4;
          end
        end
        ST_REQ: begin
          // Loads advance idx on data return instead, in WAIT.
          if (mem_gnt && store_q && idx_q != IDX_LAST) idx_q <= idx_q + 1'b1;
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            lane_q[idx_q] <= mem_rdata;
            if (idx_q != IDX_LAST) begin
              idx_q <= idx_q + 1'b1;
            end else begin
              vd_q <= vreg_q;
              for (int i = 0; i < VLEN; i++)
                vw_q[i] <= (i == VLEN - 1) ? mem_rdata : lane_q[i];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_lsu.sv
// Self-checking bench for vector_lsu. Stimulus pushes the expected memory
// transactions and bank write-backs into queues; a monitor compares them as
// the DUT presents handshakes. A responder process plays the memory.
`timescale 1ns/1ps
module tb_vector_lsu;
  import vec_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, is_store;
  logic [31:0] base_addr;
  logic [1:0]  vreg, vs_sel;
  logic [31:0] vin1, vin2, vin3, vin4;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        vw_en;
  logic [1:0]  vw_vd;
  logic [31:0] vw1, vw2, vw3, vw4;
  logic        busy, done;

  always #5 clk = ~clk;

  vector_lsu dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store),
    .base_addr(base_addr), .vreg(vreg), .vs_sel(vs_sel),
    .vin1(vin1), .vin2(vin2), .vin3(vin3), .vin4(vin4),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .vw_en(vw_en), .vw_vd(vw_vd), .vw1(vw1), .vw2(vw2), .vw3(vw3), .vw4(vw4),
    .busy(busy), .done(done)
  );

  // Vector register bank model: bank[reg][lane]
  logic [31:0] bank [4][4];
  assign vin1 = bank[vs_sel][0];
  assign vin2 = bank[vs_sel][1];
  assign vin3 = bank[vs_sel][2];
  assign vin4 = bank[vs_sel][3];

  logic [31:0] mem_model [logic [31:0]];

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_txn_t;

  typedef struct packed {
    logic [1:0]   vd;
    logic [127:0] lanes;   // {lane3, lane2, lane1, lane0}
  } wb_txn_t;

  mem_txn_t exp_mem[$];
  wb_txn_t  exp_wb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : (32'hDEAD_0000 ^ a);
  endfunction

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    mem_txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    exp_mem.push_back(t);
  endtask

  task automatic push_wb(input logic [1:0] vd, input logic [31:0] l0, input logic [31:0] l1,
                         input logic [31:0] l2, input logic [31:0] l3);
    wb_txn_t t;
    t.vd = vd; t.lanes = {l3, l2, l1, l0};
    exp_wb.push_back(t);
  endtask

  // ---------------------------------------------------------------------------
  // Memory responder: grant, optional grant stall, read return after rv_delay
  // ---------------------------------------------------------------------------
  int          rv_delay   = 0;
  int          rv_cnt     = -1;
  logic [31:0] rv_addr    = '0;
  logic [31:0] stall_addr = '0;
  int          stall_left = 0;
  bit          inject_rv  = 1'b0;

  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_rd(rv_addr);
        rv_cnt     = -1;
      end else if (rv_cnt > 0) begin
        rv_cnt--;
      end
      if (inject_rv && mem_req) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        inject_rv  = 1'b0;
      end
      if (mem_req && mem_addr == stall_addr && stall_left > 0) begin
        mem_gnt = 1'b0;
        stall_left--;
      end else begin
        mem_gnt = mem_req;
      end
      if (mem_req && mem_gnt && !mem_we) begin
        rv_cnt  = rv_delay;
        rv_addr = mem_addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  int          n_gnt = 0, n_vw = 0, n_done = 0;
  int          last_vw_cyc = 0, last_done_cyc = 0;
  logic        stalled = 1'b0;
  logic        hold_we;
  logic [31:0] hold_addr, hold_wdata;

  initial begin
    mem_txn_t m;
    wb_txn_t  w;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        if (stalled) begin
          check("hold_we", mem_we, hold_we);
          check("hold_addr", mem_addr, hold_addr);
          check("hold_wdata", mem_wdata, hold_wdata);
        end
        if (mem_gnt) begin
          n_gnt++;
          stalled = 1'b0;
          if (exp_mem.size() == 0) begin
            fail_now("unexpected_mem_req", $sformatf("addr %0h we %0b", mem_addr, mem_we));
          end else begin
            m = exp_mem.pop_front();
            check("mem_we", mem_we, m.we);
            check("mem_addr", mem_addr, m.addr);
            check("mem_wdata", mem_wdata, m.wdata);
          end
        end else begin
          stalled    = 1'b1;
          hold_we    = mem_we;
          hold_addr  = mem_addr;
          hold_wdata = mem_wdata;
        end
      end else begin
        stalled = 1'b0;
      end
      if (vw_en) begin
        n_vw++;
        last_vw_cyc = cyc;
        if (exp_wb.size() == 0) begin
          fail_now("unexpected_vw_en", $sformatf("vd %0d", vw_vd));
        end else begin
          w = exp_wb.pop_front();
          check("vw_vd", vw_vd, w.vd);
          check("vw_lanes", {vw4, vw3, vw2, vw1}, w.lanes);
        end
      end
      if (done) begin
        n_done++;
        last_done_cyc = cyc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic launch(input logic st, input logic [1:0] vr, input logic [31:0] base);
    @(negedge clk);
    is_store  = st;
    vreg      = vr;
    base_addr = base;
    start     = 1'b1;
    t0        = cyc;
    #1;
    check("vs_sel_idle", vs_sel, vr);
    @(negedge clk);
    start     = 1'b0;
    is_store  = ~st;
    vreg      = ~vr;
    base_addr = 32'h5555_5555;
    #1;
    check("vs_sel_busy", vs_sel, vr);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy) fail_now(name, "timeout waiting for idle");
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int d_done, d_vw, g0, k;

    for (int r = 0; r < 4; r++)
      for (int l = 0; l < 4; l++)
        bank[r][l] = 32'hCAFE_0000 + 32'(r * 16 + l);
    bank[2] = '{32'd1, 32'd2, 32'd3, 32'd4};
    bank[3] = '{32'h11, 32'h22, 32'h33, 32'h44};
    bank[0] = '{32'h5, 32'h6, 32'h7, 32'h8};
    mem_model[32'h200] = 32'hA; mem_model[32'h204] = 32'hB;
    mem_model[32'h208] = 32'hC; mem_model[32'h20C] = 32'hD;
    mem_model[32'h400] = 32'h1111_0000; mem_model[32'h404] = 32'h2222_0000;
    mem_model[32'h408] = 32'h3333_0000; mem_model[32'h40C] = 32'h4444_0000;

    // Reset, with start held high to show reset wins.
    rst = 1'b1; start = 1'b1; is_store = 1'b1; vreg = 2'd2; base_addr = 32'h1234;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_vw_en", vw_en, 1'b0);
    check("rst_vw_vd", vw_vd, 2'd0);
    check("rst_vw_lanes", {vw4, vw3, vw2, vw1}, 128'h0);
    check("rst_done", done, 1'b0);
    check("rst_vs_sel", vs_sel, 2'd2);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);

    // Store, zero-wait: v2 -> 0x100..0x10C, done at cycle 5.
    push_mem(1'b1, 32'h100, 32'd1); push_mem(1'b1, 32'h104, 32'd2);
    push_mem(1'b1, 32'h108, 32'd3); push_mem(1'b1, 32'h10C, 32'd4);
    d_done = n_done; d_vw = n_vw;
    launch(1'b1, 2'd2, 32'h100);
    wait_idle("store_basic", 40);
    check("store_done_cycle", last_done_cyc - t0, 5);
    check("store_done_count", n_done - d_done, 1);
    check("store_no_vw_en", n_vw - d_vw, 0);

    // Load, zero-wait: 0x200..0x20C -> v1, vw_en at 9, done at 10.
    push_mem(1'b0, 32'h200, 32'h0); push_mem(1'b0, 32'h204, 32'h0);
    push_mem(1'b0, 32'h208, 32'h0); push_mem(1'b0, 32'h20C, 32'h0);
    push_wb(2'd1, 32'hA, 32'hB, 32'hC, 32'hD);
    d_done = n_done; d_vw = n_vw;
    launch(1'b0, 2'd1, 32'h200);
    wait_idle("load_basic", 60);
    check("load_vw_cycle", last_vw_cyc - t0, 9);
    check("load_done_cycle", last_done_cyc - t0, 10);
    check("load_vw_count", n_vw - d_vw, 1);
    check("load_done_count", n_done - d_done, 1);
    check("load_vw_held", {vw4, vw3, vw2, vw1}, {32'hD, 32'hC, 32'hB, 32'hA});
    check("load_vw_en_low", vw_en, 1'b0);

    // Store with grant withheld 3 cycles on element 1.
    stall_addr = 32'h504; stall_left = 3;
    push_mem(1'b1, 32'h500, 32'h11); push_mem(1'b1, 32'h504, 32'h22);
    push_mem(1'b1, 32'h508, 32'h33); push_mem(1'b1, 32'h50C, 32'h44);
    launch(1'b1, 2'd3, 32'h500);
    wait_idle("store_stall", 60);
    check("stall_done_cycle", last_done_cyc - t0, 8);

    // Address wrap with an unaligned base.
    push_mem(1'b1, 32'hFFFF_FFF8, 32'h5); push_mem(1'b1, 32'hFFFF_FFFC, 32'h6);
    push_mem(1'b1, 32'h0000_0000, 32'h7); push_mem(1'b1, 32'h0000_0004, 32'h8);
    launch(1'b1, 2'd0, 32'hFFFF_FFFA);
    wait_idle("store_wrap", 40);

    // Load with rvalid injected in REQ and a start pulsed while busy.
    push_mem(1'b0, 32'h400, 32'h0); push_mem(1'b0, 32'h404, 32'h0);
    push_mem(1'b0, 32'h408, 32'h0); push_mem(1'b0, 32'h40C, 32'h0);
    push_wb(2'd0, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000);
    inject_rv = 1'b1;
    d_done = n_done; d_vw = n_vw;
    launch(1'b0, 2'd0, 32'h400);
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; vreg = 2'd2; base_addr = 32'h999;
    #1;
    check("busy_vs_sel_latched", vs_sel, 2'd0);
    @(negedge clk);
    start = 1'b0;
    wait_idle("load_ignore", 60);
    check("ignore_done_cycle", last_done_cyc - t0, 10);
    repeat (6) @(negedge clk);
    #2;
    check("ignore_no_restart", busy, 1'b0);
    check("ignore_vw_count", n_vw - d_vw, 1);
    check("ignore_done_count", n_done - d_done, 1);

    // Reset while waiting for element 2 of a load; late rvalid must be ignored.
    rv_delay = 3;
    push_mem(1'b0, 32'h300, 32'h0); push_mem(1'b0, 32'h304, 32'h0);
    push_mem(1'b0, 32'h308, 32'h0);
    d_done = n_done; d_vw = n_vw;
    g0 = n_gnt;
    launch(1'b0, 2'd3, 32'h300);
    k = 0;
    while (n_gnt != g0 + 3 && k < 60) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (n_gnt != g0 + 3) fail_now("abort_reach_wait", "element 2 never granted");
    @(negedge clk);
    #1;
    check("abort_in_wait_busy", busy, 1'b1);
    check("abort_in_wait_req", mem_req, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_mem_req", mem_req, 1'b0);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_vw_lanes", {vw4, vw3, vw2, vw1}, 128'h0);
    check("abort_vw_vd", vw_vd, 2'd0);
    check("abort_done", done, 1'b0);
    repeat (8) @(negedge clk);
    #2;
    rv_delay = 0;
    check("abort_no_vw_en", n_vw - d_vw, 0);
    check("abort_no_done", n_done - d_done, 0);
    check("abort_stay_idle", busy, 1'b0);
    check("abort_vw_still_zero", {vw4, vw3, vw2, vw1}, 128'h0);

    check("exp_mem_drained", exp_mem.size(), 0);
    check("exp_wb_drained", exp_wb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
